seg_scan_mux: RTL

Eight-digit time-multiplexing scanner that feeds the seven-segment decoder. It holds a 32-bit hex display word plus per-digit decimal-point and blank masks, and steps through the digits at a programmable rate. On each step it presents one 4-bit digit and a DP bit to the decoder, and drives the matching active-low anode. Loads are double-buffered and committed only at a frame boundary, so a displayed frame never mixes old and new data.

---
 rtl/seg_scan_mux.sv | 57 +++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: eight-digit time-multiplexing scanner with frame-synchronous double-buffered loads
module seg_scan_mux #(
  parameter logic [27:0] SCAN_PERIOD = 28'd100_000,
  parameter logic        LZ_BLANK    = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  output logic        pending,
  output logic        frame_done,
  output logic [3:0]  digit,
  output logic        dp,
  output logic [7:0]  AN
);
  logic [27:0] cnt;
  logic [2:0]  idx, idx1;
  logic        blk1, tick, boundary, blanked;
  logic [47:0] pend_buf, act_buf;
  logic [31:0] act_data;
  logic [7:0]  act_dp, act_blank;
  logic [3:0]  nib;
  assign {act_data, act_dp, act_blank} = act_buf;
  assign tick     = cnt == SCAN_PERIOD - 28'd1;
  assign boundary = tick && idx == 3'd7;
  assign nib      = act_data[{idx, 2'b00} +: 4];
  // nibbles idx..7 all zero is the same as the word shifted down to idx being zero
  assign blanked  = act_blank[idx] || (LZ_BLANK && idx != 3'd0 && (act_data >> {idx, 2'b00}) == 32'h0);
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      cnt        <= '0;
      idx        <= '0;
      idx1       <= '0;
      blk1       <= 1'b1;
      pend_buf   <= '0;
      act_buf    <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      digit      <= 4'h0;
      dp         <= 1'b0;
      AN         <= 8'hFF;
    end else begin
      cnt        <= tick ? '0 : cnt + 28'd1;
      idx        <= tick ? idx + 3'd1 : idx;
      if (boundary && pending) act_buf <= pend_buf;
      if (load) pend_buf <= {data_in, dp_in, blank_in};
      pending    <= load || (pending && !boundary);
      frame_done <= boundary;
      digit      <= blanked ? 4'h0 : nib;
      dp         <= act_dp[idx] && !blanked;
      blk1       <= blanked;
      idx1       <= idx;
      AN         <= blk1 ? 8'hFF : ~(8'b1 << idx1);
    end
endmodule
